// File: rtl/txuart_fifo_if.sv
// Producer write port, status flags and txuart strobe/data/busy handshake
// bundled for the txuart_fifo byte queue.
interface txuart_fifo_if #(
  parameter int LGFLEN = 4
);
  logic              i_wr;
  logic [7:0]        i_data;
  logic              o_full;
  logic              o_empty;
  logic              o_half;
  logic [LGFLEN:0]   o_fill;
  logic              o_overflow;
  logic              i_clr_ovfl;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  // FIFO side
  modport slave (
    input  i_wr, i_data, i_clr_ovfl, i_tx_busy,
    output o_full, o_empty, o_half, o_fill, o_overflow, o_tx_stb, o_tx_data
  );

  // Producer / txuart side
  modport master (
    output i_wr, i_data, i_clr_ovfl, i_tx_busy,
    input  o_full, o_empty, o_half, o_fill, o_overflow, o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/txuart_fifo.sv
// Byte FIFO feeding txuart: RAM queue plus an output register that presents
// the head byte on the strobe/data/busy handshake without bubbles.
module txuart_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  txuart_fifo_if.slave bus
);
  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0]   FILL_ONE  = {{LGFLEN{1'b0}}, 1'b1};
  localparam logic [LGFLEN:0]   FILL_MAX  = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]   FILL_HALF = {2'b01, {(LGFLEN-1){1'b0}}};
  localparam logic [LGFLEN-1:0] PTR_ONE   = {{(LGFLEN-1){1'b0}}, 1'b1};

  logic [7:0]        mem [DEPTH];

  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              half_q, half_d;
  logic              ovfl_q, ovfl_d;
  logic              tx_stb_q, tx_stb_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              accept;
  logic              consume;
  logic              load;
  logic [LGFLEN:0]   mem_cnt;

  always_comb begin
    accept  = bus.i_wr && !full_q;
    consume = tx_stb_q && !bus.i_tx_busy;
    // Bytes still in RAM: the fill count minus the one sitting in the output register.
    mem_cnt = fill_q - {{LGFLEN{1'b0}}, tx_stb_q};
    // Refill the output register whenever it is empty or being drained this edge.
    load    = (mem_cnt != '0) && (!tx_stb_q || !bus.i_tx_busy);

    wr_ptr_d = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = load   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    fill_d = fill_q;
    if (accept && !consume) begin
      fill_d = fill_q + FILL_ONE;
    end else if (!accept && consume) begin
      fill_d = fill_q - FILL_ONE;
    end

    full_d  = (fill_d == FILL_MAX);
    empty_d = (fill_d == '0);
    half_d  = (fill_d >= FILL_HALF);

    tx_stb_d  = tx_stb_q;
    tx_data_d = tx_data_q;
    if (load) begin
      tx_stb_d  = 1'b1;
      tx_data_d = mem[rd_ptr_q];
    end else if (consume) begin
      tx_stb_d  = 1'b0;
    end

    // A dropped write outranks a simultaneous clear.
    ovfl_d = ovfl_q;
    if (bus.i_wr && full_q) begin
      ovfl_d = 1'b1;
    end else if (bus.i_clr_ovfl) begin
      ovfl_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      half_q    <= 1'b0;
      ovfl_q    <= 1'b0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      half_q    <= half_d;
      ovfl_q    <= ovfl_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.o_full     = full_q;
  assign bus.o_empty    = empty_q;
  assign bus.o_half     = half_q;
  assign bus.o_fill     = fill_q;
  assign bus.o_overflow = ovfl_q;
  assign bus.o_tx_stb   = tx_stb_q;
  assign bus.o_tx_data  = tx_data_q;
endmodule

// File: doc/txuart_fifo.md
Name: txuart_fifo

Overview:
- Byte FIFO that sits directly upstream of txuart and replaces fixed-message ROM sequencing in top-level designs.
- Accepts bytes from a producer (CPU bus, test pattern generator) one per cycle.
- Presents them to txuart's strobe/data/busy handshake in order, with status for flow control.

Parameters:
- LGFLEN, 4: log2 of total capacity; block holds up to 2^LGFLEN bytes (16 by default). Legal range 2..10.

Ports:
- i_clk, input, 1: system clock; all state changes on rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_wr, input, 1: write strobe; byte on i_data offered this cycle.
- i_data, input, 8: byte to enqueue.
- o_full, output, 1: registered; high when fill == 2^LGFLEN.
- o_empty, output, 1: registered; high when fill == 0.
- o_half, output, 1: registered; high when fill >= 2^(LGFLEN-1).
- o_fill, output, LGFLEN+1: bytes held and not yet accepted by txuart, including the one being presented.
- o_overflow, output, 1: sticky; set by a write while full.
- i_clr_ovfl, input, 1: clears o_overflow.
- o_tx_stb, output, 1: to txuart request strobe; a byte is valid on o_tx_data.
- o_tx_data, output, 8: to txuart data.
- i_tx_busy, input, 1: from txuart busy.

Behaviour:
- Reset (async, any time including mid-transfer):
  - o_tx_stb=0, o_tx_data=8'h00, o_fill=0, o_empty=1, o_full=0, o_half=0, o_overflow=0.
  - All pointers zeroed; held data discarded.
  - Outputs change immediately on assertion, not at the next edge.
- Write acceptance:
  - Byte accepted at edge k iff i_wr && !o_full as sampled at edge k.
  - A write while o_full is dropped and sets o_overflow, even if a txuart accept frees a slot on the same edge.
- Read handshake:
  - Byte consumed at edge j iff o_tx_stb && !i_tx_busy at edge j.
  - o_tx_stb and o_tx_data hold stable while o_tx_stb && i_tx_busy.
- Latency:
  - Byte written at edge k into an empty block: o_tx_stb=1 with that byte on o_tx_data after edge k+1.
  - Exactly one cycle of o_tx_stb=0 between the write edge and presentation.
- No bubble: if further bytes are held when a byte is consumed at edge j, the next byte is on o_tx_data and o_tx_stb stays 1 after edge j. This requires a prefetch/output register in front of the memory.
- Fill counter:
  - o_fill increments on accept-only, decrements on consume-only, holds when both or neither occur.
  - A write to an empty block is counted in o_fill after edge k, before o_tx_stb rises.
  - o_full, o_empty and o_half are derived from the next-state fill and registered, so they are consistent with o_fill every cycle.
- Simultaneous write and consume at the same edge, not full: both take effect; order preserved; o_fill unchanged.
- Pointers:
  - LGFLEN-bit read and write pointers wrap modulo 2^LGFLEN.
  - Ordering across wrap is strictly FIFO.
- Overflow:
  - o_overflow set at an edge with i_wr && o_full.
  - Cleared at an edge with i_clr_ovfl.
  - If both occur at the same edge, set wins.
- Memory: inferred simple dual-port RAM, no reset on array contents; contents are never observable unless previously written.

Test Plan:
1. Reset, then write 8'h48 at edge 1 with i_tx_busy=0 -> o_fill=1 after edge 1; o_tx_stb=1, o_tx_data=8'h48 after edge 2; consumed at edge 3; o_empty=1, o_tx_stb=0 after edge 3.
2. Write 16 bytes 8'h00..8'h0F with i_tx_busy=1 throughout (LGFLEN=4) -> o_half=1 from fill 8, o_full=1 at fill 16; a 17th write sets o_overflow=1, o_fill stays 16. i_clr_ovfl=1 for one cycle -> o_overflow=0.
3. Release i_tx_busy and model txuart busy for 10 cycles per byte -> bytes emerge 8'h00..8'h0F in order; o_tx_data stable while busy; o_empty=1 after the last accept.
4. Write and consume at the same edge with o_fill=5 -> o_fill remains 5; run 40 continuous bytes to exercise pointer wrap twice -> output order matches input exactly.
5. Assert i_reset between edges while o_tx_stb=1 and o_fill=7 -> o_tx_stb=0, o_fill=0, o_empty=1 immediately; the next write behaves as in scenario 1.
6. Write with o_full=1 while txuart accepts on the same edge -> byte dropped, o_overflow=1, o_fill=15 after edge.
